data_memory_responder: RTL

//  Memory-side responder for the multi-cycle CPU's data/instruction memory bus.

---
 rtl/data_memory_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// Purpose : memory-side responder for the multi-cycle CPU bus; serves one held MemRead/MemWrite
//           request from an internal word RAM after WAIT_CYCLES wait states.
// Latency : request sampled at edge T -> one-cycle MemReady (and AddrError on fault) in cycle T+1+WAIT_CYCLES.
// Backpr. : requester holds its request until MemReady; requests seen during S_DONE are ignored.
// Ports   : clk, reset (async, active-low), MemRead/MemWrite/Address/WriteData in,
//           ReadData/MemReady/AddrError out, leds out only when MEM_MMIO_EN is defined.
// Config  : `define MEM_MMIO_EN maps 32'h4000_000C to an 8-bit LED register.
module data_memory_responder #(
    parameter int RAM_WORDS   = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        AddrError
`ifdef MEM_MMIO_EN
    ,
    output logic [7:0]  leds
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [31:0] MMIO_LED_ADDR = 32'h4000_000C;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef MEM_MMIO_EN
    logic [7:0]  leds_q, leds_d;
`endif

    logic [31:0] mem [RAM_WORDS];

    // Effective access: live inputs while idle (needed when WAIT_CYCLES==0 commits at the
    // accept edge), latched copy otherwise so requester changes in S_BUSY have no effect.
    logic [31:0]           acc_addr, acc_wdata;
    logic                  acc_rd, acc_wr, acc_err, acc_mmio;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  commit;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:ADDR_WIDTH+2] != '0);
    endfunction

    function automatic logic is_mmio(input logic [31:0] a);
`ifdef MEM_MMIO_EN
        return a == MMIO_LED_ADDR;
`else
        return 1'b0 && (a == MMIO_LED_ADDR);
`endif
    endfunction

    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
        acc_err   = err_q;
        if (state_q == S_IDLE) begin
            acc_addr  = Address;
            acc_wdata = WriteData;
            acc_rd    = MemRead & ~MemWrite;
            acc_wr    = MemWrite & ~MemRead;
            acc_err   = (MemRead & MemWrite) | (addr_bad(Address) & ~is_mmio(Address));
        end
        acc_mmio = is_mmio(acc_addr);
        acc_idx  = acc_addr[ADDR_WIDTH+1:2];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = acc_addr;
                    wdata_d = acc_wdata;
                    rd_d    = acc_rd;
                    wr_d    = acc_wr;
                    err_d   = acc_err;
                    cnt_d   = 4'(WAIT_CYCLES);
                    // Conflicting requests skip the wait and report the error at once.
                    if ((MemRead && MemWrite) || WAIT_CYCLES == 0)
                        state_d = S_DONE;
                    else
                        state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The edge entering S_DONE performs the access; gated by reset so an aborted
    // request can never touch the array.
    assign commit = reset && (state_d == S_DONE) && (state_q != S_DONE);

    always_comb begin
        rdata_d = rdata_q;
        if (commit && acc_rd) begin
            if (acc_err)
                rdata_d = 32'h0;
`ifdef MEM_MMIO_EN
            else if (acc_mmio)
                rdata_d = {24'h0, leds_q};
`endif
            else
                rdata_d = mem[acc_idx];
        end
`ifdef MEM_MMIO_EN
        leds_d = leds_q;
        if (commit && acc_wr && !acc_err && acc_mmio)
            leds_d = acc_wdata[7:0];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
`ifdef MEM_MMIO_EN
            leds_q  <= 8'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef MEM_MMIO_EN
            leds_q  <= leds_d;
`endif
        end
    end

    // Storage array is not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && acc_wr && !acc_err && !acc_mmio)
            mem[acc_idx] <= acc_wdata;
    end

    // Outputs
    always_comb begin
        MemReady  = (state_q == S_DONE);
        AddrError = (state_q == S_DONE) && err_q;
        ReadData  = rdata_q;
`ifdef MEM_MMIO_EN
        leds      = leds_q;
`endif
    end

endmodule
